// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: decodes RX FIFO bytes into core controls and prints "HH:MM:SS\r\n" to TX.
// Optional feature macro UART_CMD_ECHO_EN echoes recognized command bytes before acting on TX.
module uart_cmd_ctrl #(
  parameter logic [7:0] CMD_RUN   = 8'h72,
  parameter logic [7:0] CMD_CLR   = 8'h63,
  parameter logic [7:0] CMD_MODE  = 8'h6D,
  parameter logic [7:0] CMD_PRINT = 8'h70
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_empty_i,
  input  logic [7:0] rx_rdata_i,
  output logic       rx_rd_o,
  input  logic       tx_full_i,
  output logic [7:0] tx_wdata_o,
  output logic       tx_wr_o,
  input  logic [4:0] hour_i,
  input  logic [5:0] min_i,
  input  logic [5:0] sec_i,
  output logic       run_pulse_o,
  output logic       clr_pulse_o,
  output logic       mode_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    PRINT,
    PGAP
`ifdef UART_CMD_ECHO_EN
    , ECHO
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [3:0] idx_q, idx_d;
  logic [4:0] snapHour_q, snapHour_d;
  logic [5:0] snapMin_q, snapMin_d;
  logic [5:0] snapSec_q, snapSec_d;
  logic       rx_rd_q, rx_rd_d;
  logic       tx_wr_q, tx_wr_d;
  logic [7:0] tx_wdata_q, tx_wdata_d;
  logic       run_q, run_d;
  logic       clr_q, clr_d;
  logic       mode_q, mode_d;
  logic       busy_q, busy_d;
`ifdef UART_CMD_ECHO_EN
  logic       echoDone_q, echoDone_d;
`endif

  logic [7:0] cmdUp;
  logic       isRun, isClr, isMode, isPrint;
  logic [7:0] printChar;

  function automatic logic [7:0] tensChar(input logic [5:0] v);
    logic [5:0] q;
    q = v / 6'd10;
    return 8'h30 + {2'b00, q};
  endfunction

  function automatic logic [7:0] onesChar(input logic [5:0] v);
    logic [5:0] r;
    r = v % 6'd10;
    return 8'h30 + {2'b00, r};
  endfunction

  // Clearing bit 5 folds lowercase onto uppercase so either case is accepted.
  assign cmdUp   = cmd_q & 8'hDF;
  assign isRun   = (cmdUp == (CMD_RUN   & 8'hDF));
  assign isClr   = (cmdUp == (CMD_CLR   & 8'hDF));
  assign isMode  = (cmdUp == (CMD_MODE  & 8'hDF));
  assign isPrint = (cmdUp == (CMD_PRINT & 8'hDF));

  always_comb begin
    printChar = 8'h00;
    case (idx_q)
      4'd0: printChar = tensChar({1'b0, snapHour_q});
      4'd1: printChar = onesChar({1'b0, snapHour_q});
      4'd2: printChar = 8'h3A;
      4'd3: printChar = tensChar(snapMin_q);
      4'd4: printChar = onesChar(snapMin_q);
      4'd5: printChar = 8'h3A;
      4'd6: printChar = tensChar(snapSec_q);
      4'd7: printChar = onesChar(snapSec_q);
      4'd8: printChar = 8'h0D;
      4'd9: printChar = 8'h0A;
      default: printChar = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    idx_d      = idx_q;
    snapHour_d = snapHour_q;
    snapMin_d  = snapMin_q;
    snapSec_d  = snapSec_q;
    rx_rd_d    = 1'b0;
    tx_wr_d    = 1'b0;
    tx_wdata_d = tx_wdata_q;
    run_d      = 1'b0;
    clr_d      = 1'b0;
    mode_d     = mode_q;
`ifdef UART_CMD_ECHO_EN
    echoDone_d = echoDone_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_empty_i) begin
          cmd_d   = rx_rdata_i;
          rx_rd_d = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = IDLE;
        if (isRun) begin
          run_d = 1'b1;
        end else if (isClr) begin
          clr_d = 1'b1;
        end else if (isMode) begin
          mode_d = ~mode_q;
        end else if (isPrint) begin
          snapHour_d = hour_i;
          snapMin_d  = min_i;
          snapSec_d  = sec_i;
          idx_d      = 4'd0;
          state_d    = PRINT;
        end
`ifdef UART_CMD_ECHO_EN
        if (isRun || isClr || isMode || isPrint) begin
          state_d = ECHO;
        end
`endif
      end
      PRINT: begin
        if (!tx_full_i) begin
          tx_wdata_d = printChar;
          tx_wr_d    = 1'b1;
          state_d    = PGAP;
        end
      end
      // The idle gap lets tx_full reflect the previous push before the next one.
      PGAP: begin
        if (idx_q == 4'd9) begin
          idx_d   = 4'd0;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = PRINT;
        end
      end
`ifdef UART_CMD_ECHO_EN
      ECHO: begin
        if (!echoDone_q) begin
          if (!tx_full_i) begin
            tx_wdata_d = cmd_q;
            tx_wr_d    = 1'b1;
            echoDone_d = 1'b1;
          end
        end else begin
          echoDone_d = 1'b0;
          state_d    = isPrint ? PRINT : IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cmd_q      <= 8'h00;
      idx_q      <= 4'd0;
      snapHour_q <= 5'd0;
      snapMin_q  <= 6'd0;
      snapSec_q  <= 6'd0;
      rx_rd_q    <= 1'b0;
      tx_wr_q    <= 1'b0;
      tx_wdata_q <= 8'h00;
      run_q      <= 1'b0;
      clr_q      <= 1'b0;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_CMD_ECHO_EN
      echoDone_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      idx_q      <= idx_d;
      snapHour_q <= snapHour_d;
      snapMin_q  <= snapMin_d;
      snapSec_q  <= snapSec_d;
      rx_rd_q    <= rx_rd_d;
      tx_wr_q    <= tx_wr_d;
      tx_wdata_q <= tx_wdata_d;
      run_q      <= run_d;
      clr_q      <= clr_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
`ifdef UART_CMD_ECHO_EN
      echoDone_q <= echoDone_d;
`endif
    end
  end

  assign rx_rd_o     = rx_rd_q;
  assign tx_wr_o     = tx_wr_q;
  assign tx_wdata_o  = tx_wdata_q;
  assign run_pulse_o = run_q;
  assign clr_pulse_o = clr_q;
  assign mode_o      = mode_q;
  assign busy_o      = busy_q;

endmodule
